// File: rtl/periph_bus_pkg.sv
// Shared peripheral-bus definitions: arbiter state encoding and the peripheral address map
// used by bus masters and benches.
package periph_bus_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_GNT0 = 2'd1,
        ARB_GNT1 = 2'd2
    } arb_state_e;

    localparam logic [31:0] TIMER_TH   = 32'h4000_0000;
    localparam logic [31:0] TIMER_TL   = 32'h4000_0004;
    localparam logic [31:0] TIMER_TCON = 32'h4000_0008;
    localparam logic [31:0] LED        = 32'h4000_000C;
    localparam logic [31:0] SWITCH     = 32'h4000_0010;
    localparam logic [31:0] DIGI       = 32'h4000_0014;
    localparam logic [31:0] UART_TXD   = 32'h4000_0018;
    localparam logic [31:0] UART_RXD   = 32'h4000_001C;
    localparam logic [31:0] UART_CON   = 32'h4000_0020;

endpackage

// File: rtl/periph_bus_mux.sv
// Pure combinational steering between the two bus masters and the shared slave bus,
// selected by the arbiter state. Nothing reaches the slave unless a master holds the grant.
module periph_bus_mux
    import periph_bus_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  arb_state_e      i_state,
    input  logic            i_m0_req,
    input  logic            i_m0_rd,
    input  logic            i_m0_wr,
    input  logic [AW-1:0]   i_m0_addr,
    input  logic [DW-1:0]   i_m0_wdata,
    input  logic            i_m1_req,
    input  logic            i_m1_rd,
    input  logic            i_m1_wr,
    input  logic [AW-1:0]   i_m1_addr,
    input  logic [DW-1:0]   i_m1_wdata,
    input  logic [DW-1:0]   i_s_rdata,
    output logic            o_s_rd,
    output logic            o_s_wr,
    output logic [AW-1:0]   o_s_addr,
    output logic [DW-1:0]   o_s_wdata,
    output logic            o_m0_ack,
    output logic [DW-1:0]   o_m0_rdata,
    output logic            o_m1_ack,
    output logic [DW-1:0]   o_m1_rdata
);

    always_comb begin
        o_s_rd     = 1'b0;
        o_s_wr     = 1'b0;
        o_s_addr   = '0;
        o_s_wdata  = '0;
        o_m0_ack   = 1'b0;
        o_m0_rdata = '0;
        o_m1_ack   = 1'b0;
        o_m1_rdata = '0;
        case (i_state)
            ARB_GNT0: begin
                // Strobes stay gated by req: slave reads can clear status bits.
                o_s_rd     = i_m0_rd & i_m0_req;
                o_s_wr     = i_m0_wr & i_m0_req;
                o_s_addr   = i_m0_addr;
                o_s_wdata  = i_m0_wdata;
                o_m0_ack   = 1'b1;
                o_m0_rdata = i_s_rdata;
            end
            ARB_GNT1: begin
                o_s_rd     = i_m1_rd & i_m1_req;
                o_s_wr     = i_m1_wr & i_m1_req;
                o_s_addr   = i_m1_addr;
                o_s_wdata  = i_m1_wdata;
                o_m1_ack   = 1'b1;
                o_m1_rdata = i_s_rdata;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/periph_bus_arbiter.sv
// Round-robin arbiter for the shared peripheral/data-memory bus (M0 = CPU, M1 = UART/DMA).
// Define PERIPH_ARB_BURST_EN to let a locking master hold the bus for up to MAX_BURST grants.
module periph_bus_arbiter
    import periph_bus_pkg::*;
#(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int MAX_BURST = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            m0_req,
    input  logic            m0_lock,
    input  logic            m0_rd,
    input  logic            m0_wr,
    input  logic [AW-1:0]   m0_addr,
    input  logic [DW-1:0]   m0_wdata,
    output logic            m0_ack,
    output logic [DW-1:0]   m0_rdata,
    input  logic            m1_req,
    input  logic            m1_lock,
    input  logic            m1_rd,
    input  logic            m1_wr,
    input  logic [AW-1:0]   m1_addr,
    input  logic [DW-1:0]   m1_wdata,
    output logic            m1_ack,
    output logic [DW-1:0]   m1_rdata,
    output logic            s_rd,
    output logic            s_wr,
    output logic [AW-1:0]   s_addr,
    output logic [DW-1:0]   s_wdata,
    input  logic [DW-1:0]   s_rdata
);

    arb_state_e r_state;
    logic       r_last_gnt;
    logic       w_hold0;
    logic       w_hold1;

`ifdef PERIPH_ARB_BURST_EN
    localparam int             BCW        = (MAX_BURST > 2) ? $clog2(MAX_BURST) : 1;
    localparam logic [BCW-1:0] BURST_LAST = BCW'(MAX_BURST - 1);

    logic [BCW-1:0] r_burst_cnt;

    // r_burst_cnt counts extra grants beyond the first one in the current run.
    assign w_hold0 = (r_state == ARB_GNT0) && m0_req && m0_lock && (r_burst_cnt < BURST_LAST);
    assign w_hold1 = (r_state == ARB_GNT1) && m1_req && m1_lock && (r_burst_cnt < BURST_LAST);
`else
    logic w_unused;
    assign w_unused = ^{m0_lock, m1_lock, MAX_BURST[0]};
    assign w_hold0  = 1'b0;
    assign w_hold1  = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= ARB_IDLE;
            r_last_gnt <= 1'b1;
`ifdef PERIPH_ARB_BURST_EN
            r_burst_cnt <= '0;
`endif
        end else begin
`ifdef PERIPH_ARB_BURST_EN
            r_burst_cnt <= (w_hold0 || w_hold1) ? r_burst_cnt + BCW'(1) : '0;
`endif
            case (r_state)
                ARB_IDLE: begin
                    if (m0_req && (!m1_req || r_last_gnt))
                        r_state <= ARB_GNT0;
                    else if (m1_req)
                        r_state <= ARB_GNT1;
                end
                // The just-acked master is ignored at this edge: its req is still the old one.
                ARB_GNT0: begin
                    r_last_gnt <= 1'b0;
                    if (!w_hold0)
                        r_state <= m1_req ? ARB_GNT1 : ARB_IDLE;
                end
                ARB_GNT1: begin
                    r_last_gnt <= 1'b1;
                    if (!w_hold1)
                        r_state <= m0_req ? ARB_GNT0 : ARB_IDLE;
                end
                default: r_state <= ARB_IDLE;
            endcase
        end
    end

    periph_bus_mux #(
        .AW (AW),
        .DW (DW)
    ) u_mux (
        .i_state    (r_state),
        .i_m0_req   (m0_req),
        .i_m0_rd    (m0_rd),
        .i_m0_wr    (m0_wr),
        .i_m0_addr  (m0_addr),
        .i_m0_wdata (m0_wdata),
        .i_m1_req   (m1_req),
        .i_m1_rd    (m1_rd),
        .i_m1_wr    (m1_wr),
        .i_m1_addr  (m1_addr),
        .i_m1_wdata (m1_wdata),
        .i_s_rdata  (s_rdata),
        .o_s_rd     (s_rd),
        .o_s_wr     (s_wr),
        .o_s_addr   (s_addr),
        .o_s_wdata  (s_wdata),
        .o_m0_ack   (m0_ack),
        .o_m0_rdata (m0_rdata),
        .o_m1_ack   (m1_ack),
        .o_m1_rdata (m1_rdata)
    );

endmodule

// File: tb/tb_periph_bus_arbiter.sv
// Scoreboard bench for periph_bus_arbiter: two master drivers, a memory-backed slave,
// and a negedge monitor comparing every cycle against a grant/memory reference model.
module tb_periph_bus_arbiter;
    import periph_bus_pkg::*;

    localparam int AW        = 32;
    localparam int DW        = 32;
    localparam int MAX_BURST = 4;
    localparam int TMO       = 14;

    typedef struct packed {
        logic        rd;
        logic        wr;
        logic        lock;
        logic [31:0] addr;
        logic [31:0] wdata;
    } txn_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          m0_req, m0_lock, m0_rd, m0_wr, m0_ack;
    logic [AW-1:0] m0_addr;
    logic [DW-1:0] m0_wdata, m0_rdata;
    logic          m1_req, m1_lock, m1_rd, m1_wr, m1_ack;
    logic [AW-1:0] m1_addr;
    logic [DW-1:0] m1_wdata, m1_rdata;
    logic          s_rd, s_wr;
    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_wdata, s_rdata;

    periph_bus_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(MAX_BURST)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_lock(m0_lock), .m0_rd(m0_rd), .m0_wr(m0_wr),
        .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_ack(m0_ack), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_lock(m1_lock), .m1_rd(m1_rd), .m1_wr(m1_wr),
        .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_ack(m1_ack), .m1_rdata(m1_rdata),
        .s_rd(s_rd), .s_wr(s_wr), .s_addr(s_addr), .s_wdata(s_wdata), .s_rdata(s_rdata)
    );

    always #5 clk = ~clk;

    int   n_pass = 0;
    int   n_total = 0;
    txn_t q0[$];
    txn_t q1[$];
    txn_t cur[2];
    bit   busy[2];
    bit   acked[2];
    int   wait_cnt[2];
    int   ack_cnt[2];
    bit   auto_mode = 0;
    int   issue_pct = 0;
    int   lock_pct = 0;

    // Slave: word memory, RAM words in slots 0..15, peripheral registers in 16..31.
    logic [31:0] slave_mem[32];
    logic [31:0] ref_mem[32];

    function automatic int widx(input logic [31:0] a);
        return a[30] ? 16 + int'(a[5:2]) : int'(a[5:2]);
    endfunction

    assign s_rdata = s_rd ? slave_mem[widx(s_addr)] : 32'h0;
    always @(posedge clk) if (s_wr) slave_mem[widx(s_addr)] <= s_wdata;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    endtask

    function automatic txn_t mk(input logic rd, input logic wr, input logic lock,
                                input logic [31:0] addr, input logic [31:0] wdata);
        txn_t t;
        t.rd = rd; t.wr = wr; t.lock = lock; t.addr = addr; t.wdata = wdata;
        return t;
    endfunction

    task automatic drive(input int m);
        if (m == 0) begin
            m0_req = busy[0]; m0_lock = cur[0].lock; m0_rd = cur[0].rd; m0_wr = cur[0].wr;
            m0_addr = cur[0].addr; m0_wdata = cur[0].wdata;
        end else begin
            m1_req = busy[1]; m1_lock = cur[1].lock; m1_rd = cur[1].rd; m1_wr = cur[1].wr;
            m1_addr = cur[1].addr; m1_wdata = cur[1].wdata;
        end
    endtask

    task automatic issue(input int m, input txn_t t);
        cur[m] = t; busy[m] = 1; acked[m] = 0; wait_cnt[m] = 0;
        if (m == 0) q0.push_back(t); else q1.push_back(t);
        drive(m);
    endtask

    task automatic new_txn(input int m);
        txn_t t;
        t.rd    = 1'($urandom_range(1));
        t.wr    = ~t.rd;
        t.lock  = ($urandom_range(99) < lock_pct);
        t.addr  = ($urandom_range(3) == 0) ? TIMER_TH + 32'(4 * $urandom_range(8))
                                           : 32'(4 * $urandom_range(15));
        t.wdata = $urandom;
        issue(m, t);
    endtask

    // Master drivers: after an ack a locking master has already committed to a follow-on access.
    always @(posedge clk) begin
        #1;
        for (int m = 0; m < 2; m++) begin
            if (acked[m]) begin
                acked[m] = 0;
                busy[m]  = 0;
                if (cur[m].lock && reset) new_txn(m);
            end
            if (!busy[m] && auto_mode && $urandom_range(99) < issue_pct) new_txn(m);
            drive(m);
        end
    end

    // Reference model: which master owns the bus this cycle (-1 none), last winner, run length.
    int         exp_g = -1;
    int         last_w = 1;
    int         run = 0;
    int         nxt;
    bit         rs, ro, lk;
    logic [1:0] exp_vec;

    task automatic serve(input int m);
        txn_t        t;
        logic [31:0] rdat, other;
        rdat  = (m == 0) ? m0_rdata : m1_rdata;
        other = (m == 0) ? m1_rdata : m0_rdata;
        check("ack_has_pending_txn", ((m == 0) ? q0.size() : q1.size()) != 0, 1);
        if (((m == 0) ? q0.size() : q1.size()) == 0) return;
        t = (m == 0) ? q0.pop_front() : q1.pop_front();
        check("slave_strobes", {s_rd, s_wr}, {t.rd, t.wr});
        check("slave_addr", s_addr, t.addr);
        if (t.wr) begin
            check("slave_wdata", s_wdata, t.wdata);
            ref_mem[widx(t.addr)] = t.wdata;
        end
        if (t.rd) check("rdata", rdat, ref_mem[widx(t.addr)]);
        check("other_rdata_zero", other, 0);
        acked[m] = 1;
        ack_cnt[m]++;
        $display("[%0t] M%0d %s addr=0x%08h data=0x%08h", $time, m, t.wr ? "WR" : "RD",
                 t.addr, t.wr ? t.wdata : rdat);
    endtask

    always @(negedge clk) begin
        exp_vec = (exp_g == 0) ? 2'b01 : (exp_g == 1) ? 2'b10 : 2'b00;
        check("grant", {m1_ack, m0_ack}, exp_vec);
        if (m0_ack === 1'b1) serve(0);
        if (m1_ack === 1'b1) serve(1);
        if (m0_ack !== 1'b1 && m1_ack !== 1'b1) check("idle_strobes", {s_rd, s_wr}, 2'b00);

        for (int m = 0; m < 2; m++) begin
            if (busy[m] && !acked[m] && reset) begin
                wait_cnt[m]++;
                if (wait_cnt[m] >= TMO) begin
                    check("ack_within_bound", wait_cnt[m] < TMO, 1);
                    busy[m] = 0;
                    if (m == 0) q0.delete(); else q1.delete();
                end
            end
        end

        // Predict the owner of the next cycle from what the arbiter samples at the coming edge.
        if (!reset) begin
            exp_g = -1; last_w = 1; run = 0;
        end else begin
            if (exp_g == -1) begin
                if (m0_req && m1_req) nxt = 1 - last_w;
                else if (m0_req)      nxt = 0;
                else if (m1_req)      nxt = 1;
                else                  nxt = -1;
            end else begin
                rs = (exp_g == 0) ? m0_req : m1_req;
                ro = (exp_g == 0) ? m1_req : m0_req;
                lk = (exp_g == 0) ? m0_lock : m1_lock;
                last_w = exp_g;
`ifdef PERIPH_ARB_BURST_EN
                if (rs && lk && run < MAX_BURST) nxt = exp_g;
                else
`endif
                nxt = ro ? 1 - exp_g : -1;
            end
            run   = (nxt == -1) ? 0 : (nxt == exp_g) ? run + 1 : 1;
            exp_g = nxt;
        end
    end

    task automatic wait_quiet(input int bound);
        for (int i = 0; i < bound; i++) begin
            @(posedge clk); #2;
            if (!busy[0] && !busy[1]) break;
        end
        check("masters_quiet", {busy[0], busy[1]}, 2'b00);
    endtask

    int a0, a1;

    initial begin
        reset = 0;
        cur[0] = '0; cur[1] = '0;
        busy[0] = 0; busy[1] = 0; acked[0] = 0; acked[1] = 0;
        ack_cnt[0] = 0; ack_cnt[1] = 0;
        drive(0); drive(1);
        for (int i = 0; i < 32; i++) begin
            slave_mem[i] = $urandom;
            ref_mem[i]   = slave_mem[i];
        end
        slave_mem[widx(SWITCH)] = 32'h3C;
        ref_mem[widx(SWITCH)]   = 32'h3C;

        // Both masters request while reset is held: nothing may reach the slave; M0 wins first.
        @(posedge clk); #2;
        issue(0, mk(1, 0, 0, 32'h10, 0));
        issue(1, mk(1, 0, 0, 32'h20, 0));
        repeat (2) @(posedge clk);
        #2 reset = 1;
        wait_quiet(20);

        issue(0, mk(0, 1, 0, LED, 32'hA5));
        wait_quiet(20);
        check("led_written", slave_mem[widx(LED)], 32'hA5);

        issue(1, mk(1, 0, 0, SWITCH, 0));
        wait_quiet(20);

        // Both masters back to back: strict alternation, 4 accesses each in any 8 cycles.
        issue_pct = 100; lock_pct = 0; auto_mode = 1;
        repeat (3) @(posedge clk);
        #2 a0 = ack_cnt[0]; a1 = ack_cnt[1];
        repeat (8) @(posedge clk);
        #2 check("alt_m0_acks", ack_cnt[0] - a0, 4);
        check("alt_m1_acks", ack_cnt[1] - a1, 4);
        auto_mode = 0;
        wait_quiet(20);

        // Reset sampled on the edge that would open M1's grant: the write must never happen.
        issue(1, mk(0, 1, 0, 32'h24, ~ref_mem[9]));
        reset = 0;
        @(posedge clk); #2;
        reset = 1; busy[1] = 0; acked[1] = 0; q1.delete(); drive(1);
        @(posedge clk); #2;
        check("aborted_write", slave_mem[9], ref_mem[9]);

`ifdef PERIPH_ARB_BURST_EN
        lock_pct = 100;
        issue(0, mk(1, 0, 1, 32'h0, 0));
        issue(1, mk(1, 0, 0, 32'h4, 0));
        repeat (6) @(posedge clk);
        #2 lock_pct = 0;
        wait_quiet(40);
`endif

        issue_pct = 50; lock_pct = 30; auto_mode = 1;
        repeat (400) @(posedge clk);
        #2 auto_mode = 0; lock_pct = 0;
        wait_quiet(60);
        repeat (2) @(posedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
